udp_tx_arbiter: RTL and testbench

- Shares the single UDP transmit interface of eth_udp_test between NUM_REQ payload producers, for example a sensor frame source and a status/heartbeat source.
- Uses round-robin arbitration.
- Latches the winner's payload and length, then holds udp_send_data_valid until the UDP core returns udp_send_data_ready.
- Enforces a programmable inter-frame gap and reports per-requester completion.
- Sits in the rgmii_clk domain, between the clock-domain-crossing logic and eth_udp_test.

---
 rtl/udp_tx_arbiter_if.sv | 24 ++
 rtl/udp_tx_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_arbiter_if.sv
// UDP transmit handshake bundle between the arbiter (master) and eth_udp_test
// (slave). The payload bus width follows UDP_LENGTH bytes.
interface udp_tx_arbiter_if #(
    parameter int UDP_LENGTH = 960
);
    logic                    udp_send_data_valid;
    logic                    udp_send_data_ready;
    logic [UDP_LENGTH*8-1:0] udp_send_data;
    logic [15:0]             udp_send_data_length;

    modport master (
        output udp_send_data_valid,
        output udp_send_data,
        output udp_send_data_length,
        input  udp_send_data_ready
    );

    modport slave (
        input  udp_send_data_valid,
        input  udp_send_data,
        input  udp_send_data_length,
        output udp_send_data_ready
    );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the single eth_udp_test transmit port between
// NUM_REQ payload producers in the rgmii_clk domain. The winner's payload and
// length are latched, valid is held until ready, and a programmable idle gap
// separates frames. Per-requester done/err pulses report the outcome.
// Optional feature: define UDP_TX_ARB_TIMEOUT_EN to abort a frame whose ready
// has not arrived within TIMEOUT_CYCLES cycles.
module udp_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int UDP_LENGTH     = 960,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            rgmii_clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*UDP_LENGTH*8-1:0] req_data,
    input  logic [NUM_REQ*16-1:0]           req_length,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [NUM_REQ-1:0]              req_err,
    udp_tx_arbiter_if.master                udp_tx,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic [15:0]                     frame_cnt
);

    localparam int          DATA_W   = UDP_LENGTH * 8;
    localparam int          IDX_W    = $clog2(NUM_REQ);
    localparam logic [15:0] MAX_LEN  = 16'(UDP_LENGTH);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [15:0]          r_length;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;
    logic [15:0]          r_frame_cnt;
    logic [15:0]          r_gap_cnt;

    logic                 w_any;
    logic [IDX_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]   w_winner_oh;
    logic [15:0]          w_len;
    logic                 w_len_ok;
    logic                 w_arb_fire;
    logic                 w_send_done;
    logic                 w_gap_load;

`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          r_to_cnt;
    logic                 w_timeout;
`endif

    // Round-robin search: first requesting index after r_last, wrapping.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_idx    = '0;
        w_any    = 1'b0;
        w_winner = r_last;
        // Scan from farthest to nearest so the nearest requester is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_winner_oh = NUM_REQ'(1) << w_winner;
    assign w_len       = req_length[int'(w_winner)*16 +: 16];
    assign w_len_ok    = (w_len != 16'd0) && (w_len <= MAX_LEN);

    // State register.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the one-cycle control strobes of each transition.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        w_state_next = r_state;
        w_arb_fire   = 1'b0;
        w_send_done  = 1'b0;
        w_gap_load   = 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_arb_fire = 1'b1;
                    if (w_len_ok) begin
                        w_state_next = ST_SEND;
                    end else begin
                        w_state_next = ST_GAP;
                        w_gap_load   = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                // valid is always high in SEND, so ready alone completes the frame.
                if (udp_tx.udp_send_data_ready) begin
                    w_send_done  = 1'b1;
                    w_state_next = ST_GAP;
                    w_gap_load   = 1'b1;
                end
`ifdef UDP_TX_ARB_TIMEOUT_EN
                else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_GAP;
                    w_gap_load   = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                // The IDLE arbitration cycle is the last idle cycle of the gap,
                // so GAP itself lasts until the count has dropped to 2.
                if (r_gap_cnt <= 16'd2) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latch the winning frame, drive the handshake and emit outcome pulses.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the wide payload register is reset as well, since every output must read 0 in reset.
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_length    <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            if (w_arb_fire) begin
                r_last   <= w_winner;
                r_data   <= req_data[int'(w_winner)*DATA_W +: DATA_W];
                r_length <= w_len;
                if (w_len_ok) begin
                    r_grant <= w_winner_oh;
                    r_valid <= 1'b1;
                end else begin
                    r_err <= w_winner_oh;
                end
            end
            if (w_send_done) begin
                r_valid     <= 1'b0;
                r_done      <= r_grant;
                r_grant     <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
`ifdef UDP_TX_ARB_TIMEOUT_EN
            if (w_timeout) begin
                r_valid <= 1'b0;
                r_err   <= r_grant;
                r_grant <= '0;
            end
`endif
        end
    end

    // Inter-frame gap counter: loaded on leaving IDLE/SEND, counts down in GAP.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            r_gap_cnt <= '0;
        end else if (w_gap_load) begin
            r_gap_cnt <= GAP_LOAD;
        end else if ((r_state == ST_GAP) && (r_gap_cnt != 16'd0)) begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
        end
    end

`ifdef UDP_TX_ARB_TIMEOUT_EN
    // Ready watchdog: cleared when a frame enters SEND, counts while waiting.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            r_to_cnt <= '0;
        end else if (w_arb_fire) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_SEND) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`endif

    assign udp_tx.udp_send_data_valid  = r_valid;
    assign udp_tx.udp_send_data        = r_data;
    assign udp_tx.udp_send_data_length = r_length;
    assign req_done                    = r_done;
    assign req_err                     = r_err;
    assign grant                       = r_grant;
    assign busy                        = (r_state != ST_IDLE);
    assign frame_cnt                   = r_frame_cnt;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter. Stimulus tasks act as the
// requesters and push expected frames / done / err pulses into queues; an
// independent monitor pops and compares whenever the DUT presents one.
module tb_udp_tx_arbiter;
    localparam int N   = 4;
    localparam int LEN = 960;
    localparam int DW  = LEN * 8;
    localparam int GAP = 16;
    localparam int TO  = 50;

    logic            rgmii_clk = 1'b0;
    logic            rstn      = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N*16-1:0] req_length;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_err;
    logic [N-1:0]    grant;
    logic            busy;
    logic [15:0]     frame_cnt;

    udp_tx_arbiter_if #(.UDP_LENGTH(LEN)) udp_tx ();

    udp_tx_arbiter #(
        .NUM_REQ(N), .UDP_LENGTH(LEN), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .rgmii_clk  (rgmii_clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_length (req_length),
        .req_done   (req_done),
        .req_err    (req_err),
        .udp_tx     (udp_tx),
        .grant      (grant),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 rgmii_clk = ~rgmii_clk;

    typedef struct {
        int          req;
        logic [15:0] len;
        logic [DW-1:0] data;
    } frame_t;

    typedef struct {
        logic [N-1:0] bits;
        logic [15:0]  cnt;
    } pulse_t;

    frame_t q_frame[$];
    pulse_t q_done[$];
    pulse_t q_err[$];
    int     q_rise[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: round-robin pointer and expected frame count.
    int            m_last;
    logic [15:0]   m_cnt;
    logic [15:0]   len [N];
    logic [DW-1:0] pay [N];

    always @(posedge rgmii_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT event against the head of its queue.
    initial begin : monitor
        bit     pv;
        frame_t f;
        pulse_t p;
        pv = 1'b0;
        forever begin
            @(negedge rgmii_clk);
            if (!rstn) begin
                pv = 1'b0;
                continue;
            end
            if (udp_tx.udp_send_data_valid && !pv) begin
                q_rise.push_back(cyc);
                check("valid_expected", 64'(q_frame.size() > 0), 64'd1);
                if (q_frame.size() > 0) begin
                    f = q_frame.pop_front();
                    check("frame_grant", 64'(grant), 64'(N'(1) << f.req));
                    check("frame_length", 64'(udp_tx.udp_send_data_length), 64'(f.len));
                    if (udp_tx.udp_send_data !== f.data)
                        check("frame_data_low_word", 64'(udp_tx.udp_send_data[31:0]), 64'(f.data[31:0]));
                    else
                        check("frame_data", 64'd1, 64'(udp_tx.udp_send_data == f.data));
                end
            end
            pv = udp_tx.udp_send_data_valid;
            if (req_done != '0) begin
                check("done_expected", 64'(q_done.size() > 0), 64'd1);
                if (q_done.size() > 0) begin
                    p = q_done.pop_front();
                    check("done_bits", 64'(req_done), 64'(p.bits));
                    check("done_frame_cnt", 64'(frame_cnt), 64'(p.cnt));
                end
            end
            if (req_err != '0) begin
                check("err_expected", 64'(q_err.size() > 0), 64'd1);
                if (q_err.size() > 0) begin
                    p = q_err.pop_front();
                    check("err_bits", 64'(req_err), 64'(p.bits));
                    check("err_frame_cnt", 64'(frame_cnt), 64'(p.cnt));
                end
            end
        end
    end

    function automatic logic [15:0] rand_len();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'd0;
        if (r == 1) return 16'($urandom_range(LEN + 1, 65535));
        return 16'($urandom_range(1, LEN));
    endfunction

    task automatic gen_payload(input int i);
        for (int w = 0; w < DW / 32; w++) pay[i][w*32 +: 32] = $urandom();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW]   = pay[i];
            req_length[i*16 +: 16] = len[i];
        end
    endtask

    // Model: all requesters in mask present together and stay until served,
    // so they are served in rotated index order starting after m_last.
    task automatic model_round(input logic [N-1:0] mask);
        int new_last;
        new_last = m_last;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (mask[i]) begin
                new_last = i;
                if (len[i] >= 16'd1 && len[i] <= 16'(LEN)) begin
                    q_frame.push_back('{req: i, len: len[i], data: pay[i]});
                    m_cnt++;
                    q_done.push_back('{bits: N'(1) << i, cnt: m_cnt});
                end else begin
                    q_err.push_back('{bits: N'(1) << i, cnt: m_cnt});
                end
            end
        end
        m_last = new_last;
    endtask

    task automatic apply_reset();
        @(negedge rgmii_clk);
        rstn = 1'b0;
        req_valid = '0;
        udp_tx.udp_send_data_ready = 1'b0;
        repeat (2) @(negedge rgmii_clk);
        rstn = 1'b1;
        m_last = N - 1;
        m_cnt  = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge rgmii_clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    // Present mask together; each requester drops on its done/err pulse.
    // A granted requester's inputs are scrambled to prove they were latched.
    task automatic run_round(input logic [N-1:0] mask, input bit rand_ready);
        int n;
        drive_inputs();
        model_round(mask);
        req_valid = mask;
        n = 0;
        while ((req_valid != '0 || busy) && n < 3000) begin
            @(negedge rgmii_clk);
            n++;
            udp_tx.udp_send_data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            req_valid = req_valid & ~(req_done | req_err);
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    for (int w = 0; w < DW / 32; w++) req_data[i*DW + w*32 +: 32] = $urandom();
                    req_length[i*16 +: 16] = 16'($urandom());
                end
            end
        end
        udp_tx.udp_send_data_ready = 1'b0;
        check("round_completes", 64'(n < 3000), 64'd1);
        check("round_frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    endtask

    initial begin : stimulus
        int n;
        int hi;
        int dones;
        req_valid  = '0;
        req_data   = '0;
        req_length = '0;
        udp_tx.udp_send_data_ready = 1'b0;
        m_last = N - 1;
        m_cnt  = '0;

        // Reset values.
        #12;
        check("rst_valid", 64'(udp_tx.udp_send_data_valid), 64'd0);
        check("rst_data_zero", 64'(udp_tx.udp_send_data == '0), 64'd1);
        check("rst_length", 64'(udp_tx.udp_send_data_length), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_err", 64'(req_err), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        apply_reset();

        // Single frame, length 100, ready three cycles after valid.
        len[0] = 16'd100;
        gen_payload(0);
        drive_inputs();
        model_round(4'b0001);
        req_valid = 4'b0001;
        @(negedge rgmii_clk);
        check("t1_valid_latency", 64'(udp_tx.udp_send_data_valid), 64'd1);
        @(negedge rgmii_clk);
        @(negedge rgmii_clk);
        check("t1_valid_held", 64'(udp_tx.udp_send_data_valid), 64'd1);
        udp_tx.udp_send_data_ready = 1'b1;
        @(negedge rgmii_clk);
        udp_tx.udp_send_data_ready = 1'b0;
        req_valid = '0;
        check("t1_valid_dropped", 64'(udp_tx.udp_send_data_valid), 64'd0);
        check("t1_busy_in_gap", 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge rgmii_clk);
            n++;
        end
        check("t1_gap_to_idle", 64'(n), 64'(GAP - 1));

        // All four requesting continuously for 8 frames with ready high.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            len[i] = 16'($urandom_range(1, LEN));
            gen_payload(i);
        end
        drive_inputs();
        for (int f = 0; f < 8; f++) begin
            int i;
            i = (m_last + 1) % N;
            m_last = i;
            q_frame.push_back('{req: i, len: len[i], data: pay[i]});
            m_cnt++;
            q_done.push_back('{bits: N'(1) << i, cnt: m_cnt});
        end
        q_rise.delete();
        udp_tx.udp_send_data_ready = 1'b1;
        req_valid = 4'b1111;
        dones = 0;
        n = 0;
        while ((dones < 8 || busy) && n < 400) begin
            @(negedge rgmii_clk);
            n++;
            if (req_done != '0) dones++;
            if (dones == 8) req_valid = '0;
        end
        udp_tx.udp_send_data_ready = 1'b0;
        check("burst_completes", 64'(n < 400), 64'd1);
        check("burst_rises", 64'(q_rise.size()), 64'd8);
        for (int k = 1; k < q_rise.size(); k++)
            check("burst_period", 64'(q_rise[k] - q_rise[k-1]), 64'(GAP + 1));
        check("burst_frame_cnt", 64'(frame_cnt), 64'd8);

        // Randomized rounds with random ready.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                len[i] = rand_len();
                gen_payload(i);
            end
            run_round(4'($urandom_range(1, 15)), 1'b1);
        end

        // Invalid lengths: requester 2 length 0, requester 3 length 961.
        apply_reset();
        len[2] = 16'd0;
        len[3] = 16'd961;
        run_round(4'b1100, 1'b0);
        check("bad_len_frame_cnt", 64'(frame_cnt), 64'd0);

        // Reset in the middle of SEND abandons the frame.
        apply_reset();
        len[0] = 16'd50;
        gen_payload(0);
        drive_inputs();
        q_frame.push_back('{req: 0, len: len[0], data: pay[0]});
        req_valid = 4'b0001;
        @(negedge rgmii_clk);
        check("midrst_valid_up", 64'(udp_tx.udp_send_data_valid), 64'd1);
        repeat (3) @(negedge rgmii_clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_valid", 64'(udp_tx.udp_send_data_valid), 64'd0);
        check("midrst_grant", 64'(grant), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        req_valid = '0;
        @(negedge rgmii_clk);
        #2 rstn = 1'b1;
        m_last = N - 1;
        m_cnt  = '0;
        repeat (30) @(negedge rgmii_clk);
        for (int i = 0; i < 2; i++) begin
            len[i] = 16'($urandom_range(1, LEN));
            gen_payload(i);
        end
        run_round(4'b0011, 1'b0);

        // Ready withheld: timeout abort, or indefinite wait without the feature.
        len[1] = 16'd10;
        gen_payload(1);
        drive_inputs();
        q_frame.push_back('{req: 1, len: len[1], data: pay[1]});
        m_last = 1;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        q_err.push_back('{bits: 4'b0010, cnt: m_cnt});
`else
        m_cnt++;
        q_done.push_back('{bits: 4'b0010, cnt: m_cnt});
`endif
        req_valid = 4'b0010;
        @(negedge rgmii_clk);
        check("hold_valid_up", 64'(udp_tx.udp_send_data_valid), 64'd1);
`ifdef UDP_TX_ARB_TIMEOUT_EN
        hi = 1;
        while (hi < 200) begin
            @(negedge rgmii_clk);
            if (!udp_tx.udp_send_data_valid) break;
            hi++;
        end
        req_valid = '0;
        check("timeout_valid_cycles", 64'(hi), 64'(TO));
`else
        hi = 0;
        repeat (1100) begin
            @(negedge rgmii_clk);
            if (!udp_tx.udp_send_data_valid) hi++;
        end
        check("no_timeout_valid_low_cycles", 64'(hi), 64'd0);
        udp_tx.udp_send_data_ready = 1'b1;
        @(negedge rgmii_clk);
        udp_tx.udp_send_data_ready = 1'b0;
        req_valid = '0;
`endif
        wait_idle("hold_back_to_idle");
        check("hold_frame_cnt", 64'(frame_cnt), 64'(m_cnt));

        // Frame counter wrap from 0xFFFF.
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge rgmii_clk);
        release dut.r_frame_cnt;
        m_cnt = 16'hFFFF;
        len[0] = 16'($urandom_range(1, LEN));
        gen_payload(0);
        run_round(4'b0001, 1'b0);
        check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);

        repeat (5) @(negedge rgmii_clk);
        check("frames_all_seen", 64'(q_frame.size()), 64'd0);
        check("dones_all_seen", 64'(q_done.size()), 64'd0);
        check("errs_all_seen", 64'(q_err.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
